// File: rtl/game_scoreboard_display.sv
// Multiplexed 7-segment scoreboard: "L", lives, "S", then the score in decimal.
// The score is converted by a sequential double-dabble FSM and latched atomically into the display.
module game_scoreboard_display #(
  parameter int clk_mhz     = 50,
  parameter int w_digit     = 8,
  parameter int w_score     = 10,
  parameter int w_lives     = 3,
  parameter int scan_period = clk_mhz * 1000,
  parameter int blink_scans = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [w_score-1:0] score,
  input  logic [w_lives-1:0] n_lifes,
  input  logic               blank,
  output logic [7:0]         abcdefgh,
  output logic [w_digit-1:0] digit
);

  localparam int n_sd  = w_digit - 3;
  localparam int n_bcd = (w_score * 3) / 10 + 1;
  localparam int w_pre = (scan_period > 1) ? $clog2(scan_period) : 1;
  localparam int w_idx = $clog2(w_digit);
  localparam int w_blk = (blink_scans > 1) ? $clog2(blink_scans) : 1;
  localparam int w_cnt = $clog2(w_score + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  function automatic logic [7:0] segOf(input logic [3:0] d);
    case (d)
      4'd0:    segOf = 8'hFC;
      4'd1:    segOf = 8'h60;
      4'd2:    segOf = 8'hDA;
      4'd3:    segOf = 8'hF2;
      4'd4:    segOf = 8'h66;
      4'd5:    segOf = 8'hB6;
      4'd6:    segOf = 8'hBE;
      4'd7:    segOf = 8'hE0;
      4'd8:    segOf = 8'hFE;
      4'd9:    segOf = 8'hF6;
      default: segOf = 8'h00;
    endcase
  endfunction

  logic [w_pre-1:0]     r_prescCnt;
  logic [w_idx-1:0]     r_scanIdx;
  logic                 w_tick;
  logic                 w_roundDone;
  logic [w_blk-1:0]     r_blinkCnt;
  logic                 r_phaseOn;
  logic                 w_gameOver;
  state_t               r_state;
  state_t               w_nextState;
  logic [w_score-1:0]   r_latched;
  logic [w_score-1:0]   r_bin;
  logic [4*n_bcd-1:0]   r_bcd;
  logic [4*n_bcd-1:0]   w_bcdAdj;
  logic [4*n_bcd-1:0]   r_disp;
  logic [w_cnt-1:0]     r_shiftCnt;
  logic                 w_changed;
  logic [w_idx+1:0]     w_nibBase;
  logic [3:0]           w_nib;
  logic                 w_leadZero;
  logic                 w_overflow;
  logic                 w_livesDash;
  logic [3:0]           w_livesNib;
  logic [7:0]           w_glyph;

  assign w_tick      = (r_prescCnt == w_pre'(scan_period - 1));
  assign w_roundDone = w_tick && (r_scanIdx == w_idx'(w_digit - 1));
  assign w_gameOver  = (n_lifes == '0);
  assign w_changed   = (score != r_latched);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prescCnt <= '0;
      r_scanIdx  <= '0;
    end else if (w_tick) begin
      r_prescCnt <= '0;
      r_scanIdx  <= w_roundDone ? '0 : r_scanIdx + w_idx'(1);
    end else begin
      r_prescCnt <= r_prescCnt + w_pre'(1);
    end
  end

  // Blink counts whole scan rounds, and only while the game is over.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blinkCnt <= '0;
      r_phaseOn  <= 1'b1;
    end else if (!w_gameOver) begin
      r_blinkCnt <= '0;
      r_phaseOn  <= 1'b1;
    end else if (w_roundDone) begin
      if (r_blinkCnt == w_blk'(blink_scans - 1)) begin
        r_blinkCnt <= '0;
        r_phaseOn  <= ~r_phaseOn;
      end else begin
        r_blinkCnt <= r_blinkCnt + w_blk'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_changed) w_nextState = SHIFT;
      SHIFT:   if (w_changed) w_nextState = SHIFT;
               else if (r_shiftCnt == w_cnt'(w_score - 1)) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_bcdAdj = r_bcd;
    for (int i = 0; i < n_bcd; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_bcdAdj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  // A score change while idle or shifting (re)starts the conversion from the new value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_latched  <= '0;
      r_bin      <= '0;
      r_bcd      <= '0;
      r_shiftCnt <= '0;
      r_disp     <= '0;
    end else if ((r_state != DONE) && w_changed) begin
      r_latched  <= score;
      r_bin      <= score;
      r_bcd      <= '0;
      r_shiftCnt <= '0;
    end else if (r_state == SHIFT) begin
      {r_bcd, r_bin} <= {w_bcdAdj, r_bin} << 1;
      r_shiftCnt     <= r_shiftCnt + w_cnt'(1);
    end else if (r_state == DONE) begin
      r_disp <= r_bcd;
    end
  end

  assign w_nibBase   = {r_scanIdx, 2'b00};
  assign w_overflow  = ((r_disp >> (4 * n_sd)) != '0);
  assign w_livesDash = (32'(n_lifes) > 32'd9);
  assign w_livesNib  = 4'(n_lifes);

  always_comb begin
    w_nib      = 4'(r_disp >> w_nibBase);
    w_leadZero = (r_scanIdx != '0) && ((r_disp >> w_nibBase) == '0);
    w_glyph    = 8'h00;
    if (r_scanIdx == w_idx'(w_digit - 1))      w_glyph = 8'h1C;
    else if (r_scanIdx == w_idx'(w_digit - 2)) w_glyph = w_livesDash ? 8'h02 : segOf(w_livesNib);
    else if (r_scanIdx == w_idx'(w_digit - 3)) w_glyph = 8'hB6;
    else if (w_overflow)                       w_glyph = 8'h02;
    else if (w_leadZero)                       w_glyph = 8'h00;
    else                                       w_glyph = segOf(w_nib);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit    <= '0;
      abcdefgh <= 8'h00;
    end else begin
      digit    <= w_digit'(1) << r_scanIdx;
      abcdefgh <= (blank || !r_phaseOn) ? 8'h00 : w_glyph;
    end
  end

endmodule
